t01_clkmon: RTL and testbench
=============================

T01_CLKMON -- requirements
Module: t01_clkmon

Interface
REQ-001 Parameter PERIOD_MIN, default 2490: smallest in-range period, in clk cycles.
REQ-002 Parameter PERIOD_MAX, default 2514: largest in-range period, in clk cycles.
REQ-003 Parameter TIMEOUT, default 4000: cycle count without a rising edge that declares a missing clock.
REQ-004 Parameter LOCK_N, default 4: consecutive in-range periods required for lock.
REQ-005 clk  in  1  system clock; sole clock domain.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 sclk_in  in  1  monitored slow clock (e.g. divided 10 kHz clock); asynchronous to clk.
REQ-008 en  in  1  monitor enable; low forces IDLE.
REQ-009 clear_fault  in  1  single-cycle pulse; clears the sticky fault and overrun flags.
REQ-010 period_out  out  12  last measured period, in clk cycles.
REQ-011 period_valid  out  1  period_out holds an unconsumed measurement.
REQ-012 period_ready  in  1  consumer accepts period_out.
REQ-013 lock  out  1  LOCK_N consecutive in-range periods seen.
REQ-014 fault  out  1  sticky: timeout or out-of-range period seen.
REQ-015 overrun  out  1  sticky: a measurement was dropped.

Function
REQ-016 sclk_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a history flop s3; rise = s2 & ~s3.
REQ-017 A rising edge of sclk_in sampled at clk edge N SHALL produce rise during cycle N+2.
REQ-018 FSM states SHALL be IDLE, WAIT_EDGE and MEASURE.
REQ-019 IDLE: en=1 -> WAIT_EDGE. Any state: en=0 -> IDLE next cycle; lock cleared; counter cleared; sticky flags and period_valid retained.
REQ-020 WAIT_EDGE: rise -> MEASURE with cnt=1. cnt reaching TIMEOUT -> fault=1, cnt=0, state remains WAIT_EDGE.
REQ-021 MEASURE: cnt SHALL increment by 1 each cycle without rise, saturating at 4095.
REQ-022 MEASURE with rise: measurement = cnt; cnt reloads to 1; state remains MEASURE.
REQ-023 MEASURE with cnt reaching TIMEOUT and no rise: fault=1, lock=0, in-range streak=0, state -> WAIT_EDGE, cnt=0, no measurement produced.
REQ-024 In range means PERIOD_MIN <= measurement <= PERIOD_MAX, inclusive at both ends.
REQ-025 In-range measurement: streak increments, saturating at LOCK_N; lock=1 on the cycle after streak reaches LOCK_N.
REQ-026 Out-of-range measurement: streak=0, lock=0, fault=1.
REQ-027 Every measurement, in range or not, SHALL be offered through the valid/ready handshake.
REQ-028 Handshake: transfer occurs on a cycle with period_valid & period_ready. period_out SHALL stay stable while period_valid=1 and period_ready=0.
REQ-029 New measurement with period_valid=0: period_out=measurement, period_valid=1 next cycle.
REQ-030 New measurement with period_valid=1 and period_ready=1 in the same cycle: old value transfers; new value loads; period_valid stays 1.
REQ-031 New measurement with period_valid=1 and period_ready=0: new value dropped, overrun=1, period_out unchanged.
REQ-032 clear_fault=1 SHALL clear fault and overrun next cycle; a fault or overrun event in the same cycle wins (flag stays 1).
REQ-033 All outputs SHALL be registered.

Reset
REQ-034 rst=1 SHALL asynchronously set: state=IDLE, s1=s2=s3=0, cnt=0, streak=0, period_out=0, period_valid=0, lock=0, fault=0, overrun=0.
REQ-035 rst asserted mid-measurement SHALL discard the partial count; after release, the first rise starts a fresh measurement with no period produced from it.

Verification
REQ-036 en=1; sclk_in square wave of period 2502 clk, ready=1 -> first measurement after the second rise; each period_out=2502; lock=1 after the 4th measurement; fault=0.
REQ-037 Locked; one sclk_in period of 2600 -> period_out=2600, lock=0, fault=1; next 4 nominal periods -> lock=1, fault remains 1 until clear_fault.
REQ-038 Locked; sclk_in held at 0 -> fault=1 and lock=0 exactly TIMEOUT=4000 cycles after the last rise's count reload; state WAIT_EDGE; a restarted clock relocks after 4 periods.
REQ-039 ready=0 across two measurements (2502, 2503) -> period_out=2502, period_valid=1, overrun=1; ready=1 -> 2502 transfers, period_valid=0.
REQ-040 Periods 2490 and 2514 -> in range, no fault; periods 2489 and 2515 -> fault=1 each.
REQ-041 rst pulse mid-period, and separately en=0 mid-period -> all outputs at reset values (for en=0: lock=0, flags retained); no spurious measurement after the first post-release rise.

Source files
------------

// File: rtl/t01_clkmon.sv
// Slow-clock monitor: measures sclk_in periods in clk cycles, tracks lock on a run of
// in-range periods, and raises sticky fault/overrun flags. Results leave on a valid/ready port.
module t01_clkmon #(
   parameter int PERIOD_MIN = 2490,
   parameter int PERIOD_MAX = 2514,
   parameter int TIMEOUT    = 4000,
   parameter int LOCK_N     = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sclk_in,
   input  logic        en,
   input  logic        clear_fault,
   output logic [11:0] period_out,
   output logic        period_valid,
   input  logic        period_ready,
   output logic        lock,
   output logic        fault,
   output logic        overrun,
   output logic [1:0]  dbg_state
);

   localparam int          SW      = $clog2(LOCK_N + 1);
   localparam logic [11:0] MIN_C   = 12'(PERIOD_MIN);
   localparam logic [11:0] MAX_C   = 12'(PERIOD_MAX);
   localparam logic [11:0] TMO_C   = 12'(TIMEOUT);
   localparam logic [11:0] CNT_MAX = 12'hFFF;
   localparam logic [SW-1:0] LOCK_C = SW'(LOCK_N);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_EDGE = 2'd1,
      MEASURE   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [11:0]   cnt_q, cnt_d;
   logic [SW-1:0] streak_q, streak_d;
   logic          lock_d;
   logic          s1, s2, s3;
   logic          rise;
   logic          meas;
   logic          fault_set;
   logic          in_range;
   logic [11:0]   pout_d;
   logic          pvalid_d;
   logic          fault_d;
   logic          overrun_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sclk_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise      = s2 & ~s3;
   assign in_range  = (cnt_q >= MIN_C) && (cnt_q <= MAX_C);
   assign dbg_state = state_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      streak_d  = streak_q;
      lock_d    = (streak_q == LOCK_C);
      meas      = 1'b0;
      fault_set = 1'b0;
      if (!en) begin
         state_d  = IDLE;
         cnt_d    = '0;
         streak_d = '0;
         lock_d   = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = WAIT_EDGE;
               cnt_d   = '0;
            end
            WAIT_EDGE: begin
               // The first edge only arms the counter; no period exists yet.
               if (rise) begin
                  state_d = MEASURE;
                  cnt_d   = 12'd1;
               end else if (cnt_q == TMO_C) begin
                  fault_set = 1'b1;
                  cnt_d     = '0;
               end else begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
            MEASURE: begin
               if (rise) begin
                  meas  = 1'b1;
                  cnt_d = 12'd1;
                  if (in_range) begin
                     if (streak_q != LOCK_C) streak_d = streak_q + SW'(1);
                  end else begin
                     streak_d  = '0;
                     lock_d    = 1'b0;
                     fault_set = 1'b1;
                  end
               end else if (cnt_q == TMO_C) begin
                  fault_set = 1'b1;
                  lock_d    = 1'b0;
                  streak_d  = '0;
                  state_d   = WAIT_EDGE;
                  cnt_d     = '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 12'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Valid/ready: a word moves on any cycle with period_valid & period_ready; while valid is
   // high and ready low, period_out holds. A new measurement reuses the slot only if it is
   // empty or being drained this cycle; otherwise it is dropped and overrun is raised.
   always_comb begin
      pout_d    = period_out;
      pvalid_d  = period_valid;
      fault_d   = fault & ~clear_fault;
      overrun_d = overrun & ~clear_fault;
      if (meas) begin
         if (!period_valid || period_ready) begin
            pout_d   = cnt_q;
            pvalid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (period_valid && period_ready) begin
         pvalid_d = 1'b0;
      end
      if (fault_set) fault_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         streak_q     <= '0;
         lock         <= 1'b0;
         period_out   <= '0;
         period_valid <= 1'b0;
         fault        <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         streak_q     <= streak_d;
         lock         <= lock_d;
         period_out   <= pout_d;
         period_valid <= pvalid_d;
         fault        <= fault_d;
         overrun      <= overrun_d;
      end
   end

endmodule

// File: tb/tb_t01_clkmon.sv
// Bench for t01_clkmon: sclk_in rises are scheduled on clk negedges; the reference model
// derives each expected period from the clk cycles elapsed between successive rises.
module tb_t01_clkmon;

   localparam int PMIN   = 2490;
   localparam int PMAX   = 2514;
   localparam int TMO    = 4000;
   localparam int LOCK_N = 4;
   localparam int NOM    = 2502;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sclk_in = 1'b0;
   logic        en = 1'b0;
   logic        clear_fault = 1'b0;
   logic        period_ready = 1'b1;
   logic [11:0] period_out;
   logic        period_valid;
   logic        lock;
   logic        fault;
   logic        overrun;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int ready_mode = 1;
   int rdy_cnt = 0;

   logic [11:0] exp_q[$];
   logic [11:0] mon_v;
   int m_streak = 0;
   bit m_fault = 1'b0;
   bit m_overrun = 1'b0;
   bit have_prev = 1'b0;
   int last_rise = 0;

   t01_clkmon dut (
      .clk          (clk),
      .rst          (rst),
      .sclk_in      (sclk_in),
      .en           (en),
      .clear_fault  (clear_fault),
      .period_out   (period_out),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .lock         (lock),
      .fault        (fault),
      .overrun      (overrun),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (ready_mode == 0) period_ready = 1'b0;
      else if (ready_mode == 1) period_ready = 1'b1;
      else begin
         rdy_cnt++;
         period_ready = (rdy_cnt % 8 == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Scoreboard: every transfer must match the oldest expected period.
   always @(negedge clk) begin
      #1;
      if (!rst && period_valid && period_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_transfer: got period_out=%0d, expected no transfer", period_out);
         end else begin
            mon_v = exp_q.pop_front();
            if (period_out !== mon_v) begin
               errors++;
               $display("FAIL period_value: got %0d expected %0d", period_out, mon_v);
            end
         end
      end
   end

   function automatic bit m_lock();
      return (m_streak == LOCK_N);
   endfunction

   // A rise closes the previous period (if one was open) and opens a new one.
   task automatic model_rise();
      int gap;
      if (have_prev) begin
         gap = cyc - last_rise;
         if (ready_mode == 0 && exp_q.size() != 0) m_overrun = 1'b1;
         else exp_q.push_back(12'(gap));
         if (gap >= PMIN && gap <= PMAX) begin
            if (m_streak < LOCK_N) m_streak++;
         end else begin
            m_streak = 0;
            m_fault  = 1'b1;
         end
      end
      last_rise = cyc;
      have_prev = 1'b1;
   endtask

   task automatic send_period(input int p);
      sclk_in = 1'b1;
      model_rise();
      repeat (p / 2) @(negedge clk);
      sclk_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
   endtask

   task automatic clear_pulse();
      clear_fault = 1'b1;
      @(negedge clk);
      clear_fault = 1'b0;
      m_fault   = 1'b0;
      m_overrun = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({period_out, period_valid, lock, fault, overrun} !== 16'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0", {period_out, period_valid, lock, fault, overrun});
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (period_valid !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_valid: got %0b expected 0", period_valid);
      end
   endtask

   task automatic test_nominal();
      en = 1'b1;
      ready_mode = 1;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         send_period(NOM);
         checks++;
         if (lock !== m_lock()) begin
            errors++;
            $display("FAIL nominal_lock[%0d]: got %0b expected %0b", k, lock, m_lock());
         end
         checks++;
         if (fault !== m_fault) begin
            errors++;
            $display("FAIL nominal_fault[%0d]: got %0b expected %0b", k, fault, m_fault);
         end
      end
      checks++;
      if (lock !== 1'b1) begin
         errors++;
         $display("FAIL nominal_locked: got %0b expected 1", lock);
      end
   endtask

   task automatic test_out_of_range();
      int args[8] = '{2489, 2514, 2599, NOM, NOM, NOM, NOM, NOM};
      bit clr[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 8; k++) begin
         send_period(args[k]);
         checks++;
         if (lock !== m_lock()) begin
            errors++;
            $display("FAIL oor_lock[%0d]: got %0b expected %0b", k, lock, m_lock());
         end
         checks++;
         if (fault !== m_fault) begin
            errors++;
            $display("FAIL oor_fault[%0d]: got %0b expected %0b", k, fault, m_fault);
         end
         if (clr[k]) begin
            clear_pulse();
            checks++;
            if (fault !== 1'b0) begin
               errors++;
               $display("FAIL oor_clear[%0d]: got %0b expected 0", k, fault);
            end
         end
      end
   endtask

   task automatic test_timeout();
      sclk_in = 1'b1;
      model_rise();
      for (int k = 1; k <= TMO + 3; k++) begin
         @(negedge clk);
         if (k == 1251) sclk_in = 1'b0;
         if (k == TMO + 2) begin
            checks++;
            if ({fault, lock} !== 2'b01) begin
               errors++;
               $display("FAIL timeout_early: got fault=%0b lock=%0b expected fault=0 lock=1", fault, lock);
            end
         end
      end
      m_fault   = 1'b1;
      m_streak  = 0;
      have_prev = 1'b0;
      checks++;
      if ({fault, lock} !== 2'b10) begin
         errors++;
         $display("FAIL timeout_edge: got fault=%0b lock=%0b expected fault=1 lock=0", fault, lock);
      end
      checks++;
      if (dbg_state !== ST_WAIT) begin
         errors++;
         $display("FAIL timeout_state: got %0d expected %0d", dbg_state, ST_WAIT);
      end
      clear_pulse();
      // Restart with the in-range extremes among the relocking periods.
      for (int k = 0; k < 5; k++) begin
         send_period((k == 0) ? 2490 : ((k == 1) ? 2514 : NOM));
         checks++;
         if ({lock, fault} !== {m_lock(), m_fault}) begin
            errors++;
            $display("FAIL relock[%0d]: got lock=%0b fault=%0b expected lock=%0b fault=%0b", k, lock, fault, m_lock(), m_fault);
         end
      end
      checks++;
      if (lock !== 1'b1) begin
         errors++;
         $display("FAIL relock_final: got %0b expected 1", lock);
      end
   endtask

   task automatic test_overrun();
      send_period(NOM);
      ready_mode = 0;
      send_period(2503);
      checks++;
      if ({period_valid, period_out} !== {1'b1, 12'd2502}) begin
         errors++;
         $display("FAIL hold_first: got valid=%0b out=%0d expected valid=1 out=2502", period_valid, period_out);
      end
      send_period(NOM);
      checks++;
      if (period_out !== 12'd2502) begin
         errors++;
         $display("FAIL overrun_out: got %0d expected 2502", period_out);
      end
      checks++;
      if (period_valid !== 1'b1) begin
         errors++;
         $display("FAIL overrun_valid: got %0b expected 1", period_valid);
      end
      checks++;
      if (overrun !== m_overrun) begin
         errors++;
         $display("FAIL overrun_flag: got %0b expected %0b", overrun, m_overrun);
      end
      ready_mode = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (period_valid !== 1'b0) begin
         errors++;
         $display("FAIL drain_valid: got %0b expected 0", period_valid);
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
      end
   endtask

   task automatic test_en_off();
      sclk_in = 1'b1;
      model_rise();
      repeat (1000) @(negedge clk);
      en = 1'b0;
      repeat (3) @(negedge clk);
      m_streak  = 0;
      have_prev = 1'b0;
      checks++;
      if (lock !== 1'b0) begin
         errors++;
         $display("FAIL en_off_lock: got %0b expected 0", lock);
      end
      checks++;
      if ({fault, overrun} !== {m_fault, m_overrun}) begin
         errors++;
         $display("FAIL en_off_flags: got fault=%0b overrun=%0b expected fault=%0b overrun=%0b", fault, overrun, m_fault, m_overrun);
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL en_off_state: got %0d expected %0d", dbg_state, ST_IDLE);
      end
      sclk_in = 1'b0;
      repeat (200) @(negedge clk);
      en = 1'b1;
      repeat (5) @(negedge clk);
      send_period(NOM);
      send_period(NOM);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL en_off_one_meas: got %0d pending expected 0", exp_q.size());
      end
      checks++;
      if (lock !== m_lock()) begin
         errors++;
         $display("FAIL en_off_relock: got %0b expected %0b", lock, m_lock());
      end
      clear_pulse();
      checks++;
      if (overrun !== 1'b0) begin
         errors++;
         $display("FAIL overrun_clear: got %0b expected 0", overrun);
      end
   endtask

   task automatic test_reset_mid();
      sclk_in = 1'b1;
      model_rise();
      repeat (800) @(negedge clk);
      sclk_in = 1'b0;
      repeat (300) @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if ({period_out, period_valid, lock, fault, overrun} !== 16'd0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h expected 0", {period_out, period_valid, lock, fault, overrun});
      end
      checks++;
      if (dbg_state !== ST_IDLE) begin
         errors++;
         $display("FAIL mid_reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
      end
      m_fault   = 1'b0;
      m_overrun = 1'b0;
      m_streak  = 0;
      have_prev = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      send_period(NOM);
      send_period(NOM);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_reset_one_meas: got %0d pending expected 0", exp_q.size());
      end
      checks++;
      if ({lock, fault} !== {m_lock(), m_fault}) begin
         errors++;
         $display("FAIL mid_reset_flags: got lock=%0b fault=%0b expected lock=%0b fault=%0b", lock, fault, m_lock(), m_fault);
      end
   endtask

   task automatic test_random();
      ready_mode = 2;
      for (int k = 0; k < 4; k++) begin
         send_period($urandom_range(2480, 2525));
         checks++;
         if ({lock, fault} !== {m_lock(), m_fault}) begin
            errors++;
            $display("FAIL random[%0d]: got lock=%0b fault=%0b expected lock=%0b fault=%0b", k, lock, fault, m_lock(), m_fault);
         end
      end
   endtask

   task automatic test_drain();
      ready_mode = 1;
      repeat (20) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
      end
      checks++;
      if (overrun !== m_overrun) begin
         errors++;
         $display("FAIL final_overrun: got %0b expected %0b", overrun, m_overrun);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_out_of_range();
      test_timeout();
      test_overrun();
      test_en_off();
      test_reset_mid();
      test_random();
      test_drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
